// File: rtl/addsub_mac_pipe.sv
// 3-stage (a +/- b) * c datapath with valid/ready backpressure, optional accumulate,
// and zero-operand multiplier gating with a saturating gated-result counter.
`timescale 1ns/1ps
module addsub_mac_pipe #(
  parameter int W     = 8,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_clr,
  output logic [OUT_W-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gate_cnt
);

  logic en1, en2, en3, load3;

  logic             v1_q, v2_q, v3_q;
  logic [W-1:0]     a1_q, b1_q, c1_q;
  logic [1:0]       mode1_q;
  logic [W:0]       sum2_q;
  logic [W-1:0]     c2_q;
  logic             z2_q, accm2_q;
  logic [OUT_W-1:0] d_q, d_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;

  logic [W:0]       sum_d;
  logic             z_d;
  logic [2*W:0]     prod_full;
  logic [OUT_W-1:0] prod, acc_base, acc_sum;

  // Enable chain runs from the sink backwards so bubbles collapse.
  assign en3      = !v3_q | out_ready;
  assign en2      = !v2_q | en3;
  assign en1      = !v1_q | en2;
  assign in_ready = en1;
  assign load3    = en3 & v2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      c1_q    <= '0;
      mode1_q <= '0;
    end else if (en1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a1_q    <= a;
        b1_q    <= b;
        c1_q    <= c;
        mode1_q <= mode;
      end
    end
  end

  assign sum_d = mode1_q[0] ? ({1'b0, a1_q} + {1'b0, b1_q})
                            : ({1'b0, a1_q} - {1'b0, b1_q});
  assign z_d   = (c1_q == '0);

  // Multiplier operands hold on zero beats so the multiplier inputs do not toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_q    <= 1'b0;
      sum2_q  <= '0;
      c2_q    <= '0;
      z2_q    <= 1'b0;
      accm2_q <= 1'b0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        z2_q    <= z_d;
        accm2_q <= mode1_q[1];
        if (!z_d) begin
          sum2_q <= sum_d;
          c2_q   <= c1_q;
        end
      end
    end
  end

  assign prod_full = {{W{1'b0}}, sum2_q} * {{(W+1){1'b0}}, c2_q};
  assign prod      = z2_q ? '0 : prod_full[OUT_W-1:0];
  assign acc_base  = acc_clr ? '0 : acc_q;
  assign acc_sum   = acc_base + prod;

  always_comb begin
    d_d        = d_q;
    acc_d      = acc_q;
    gate_cnt_d = gate_cnt_q;
    if (load3) begin
      d_d = accm2_q ? acc_sum : prod;
      if (z2_q && (gate_cnt_q != '1))
        gate_cnt_d = gate_cnt_q + CNT_W'(1);
    end
    if (load3 && accm2_q)
      acc_d = acc_sum;
    else if (acc_clr)
      acc_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3_q       <= 1'b0;
      d_q        <= '0;
      acc_q      <= '0;
      gate_cnt_q <= '0;
    end else begin
      if (en3)
        v3_q <= v2_q;
      d_q        <= d_d;
      acc_q      <= acc_d;
      gate_cnt_q <= gate_cnt_d;
    end
  end

  assign d         = d_q;
  assign out_valid = v3_q;
  assign gate_cnt  = gate_cnt_q;

endmodule

// File: tb/tb_addsub_mac_pipe.sv
// Randomised and directed bench for addsub_mac_pipe against an arithmetic reference model.
`timescale 1ns/1ps
module tb_addsub_mac_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a, b, c;
  logic [1:0]  mode;
  logic        in_valid, acc_clr, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] d, gate_cnt;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] acc_m = '0;
  int          g_m   = 0;
  bit          clr_next = 1'b0;
  int          n_acc = 0;
  int          cyc   = 0;
  bit          done;

  addsub_mac_pipe #(.W(8), .OUT_W(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .acc_clr(acc_clr),
    .d(d), .out_valid(out_valid), .out_ready(out_ready), .gate_cnt(gate_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // (a +/- b) taken modulo 512, times c, low 16 bits
  function automatic logic [15:0] ref_prod(input int av, input int bv, input int cv, input logic [1:0] m);
    int s;
    s = m[0] ? av + bv : av - bv;
    s = (s + 512) % 512;
    return 16'((s * cv) % 65536);
  endfunction

  // Model updates at acceptance; accumulate state is in-order, so this matches S3 timing.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(d), 32'hFFFF_FFFF);
        else begin
          chk("d_vs_model", 32'(d), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        logic [15:0] p, e;
        p = ref_prod(int'(a), int'(b), int'(c), mode);
        if (mode[1]) begin
          acc_m = (clr_next ? 16'd0 : acc_m) + p;
          e = acc_m;
        end else e = p;
        clr_next = 1'b0;
        if (c == 8'd0) g_m++;
        n_acc++;
        exp_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv, input logic [1:0] mv);
    int n = 0;
    a = av; b = bv; c = cv; mode = mv; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    acc_m = '0;
  endtask

  // Call right after send() of a lone beat into an empty pipe.
  task automatic lat_check(input string tag, input logic [15:0] v);
    @(negedge clk); chk({tag, "_ov_c1"}, 32'(out_valid), 32'd0);
    @(negedge clk); chk({tag, "_ov_c2"}, 32'(out_valid), 32'd0);
    @(negedge clk); chk({tag, "_ov_c3"}, 32'(out_valid), 32'd1);
    chk({tag, "_d"}, 32'(d), 32'(v));
    @(posedge clk); #1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] v);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(d), 32'(v));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int t0, g0, a0;
    reset = 1'b1; a = '0; b = '0; c = '0; mode = '0;
    in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_gate_cnt", 32'(gate_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // 1: max operands, latency 3
    send(8'hFF, 8'hFF, 8'hFF, 2'b01);
    lat_check("t1", 16'hFC02);

    // 2: subtract wrap, then random back-to-back
    send(8'h10, 8'h20, 8'h03, 2'b00);
    expect_out("t2_wrap", 16'h05D0);
    drain();
    t0 = cyc;
    for (int i = 0; i < 300; i++)
      send(8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), 2'($urandom));
    chk("t2_throughput_cycles", 32'(cyc - t0), 32'd300);
    drain();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++)
          send(8'($urandom), 8'($urandom), 8'($urandom_range(0, 3)), 2'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("t2_gate_cnt", 32'(gate_cnt), 32'(g_m));

    // 3: zero-c gating
    g0 = g_m;
    send(8'h12, 8'h34, 8'h00, 2'b00);
    send(8'h56, 8'h78, 8'h00, 2'b01);
    send(8'h9A, 8'hBC, 8'h00, 2'b10);
    send(8'hDE, 8'hF0, 8'h00, 2'b11);
    send(8'h11, 8'h22, 8'h00, 2'b01);
    for (int i = 0; i < 5; i++)
      send(8'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 2'($urandom_range(0, 1)));
    drain();
    chk("t3_gate_delta", 32'(gate_cnt), 32'(g0 + 5));

    // 4: accumulate
    pulse_clr();
    send(8'd1, 8'd2, 8'd3, 2'b11);
    expect_out("t4_acc1", 16'h0009);
    send(8'd4, 8'd4, 8'd2, 2'b11);
    expect_out("t4_acc2", 16'h0019);
    pulse_clr();
    send(8'd5, 8'd3, 8'd2, 2'b10);
    expect_out("t4_accsub", 16'h0004);
    clr_next = 1'b1;
    send(8'd2, 8'd1, 8'd3, 2'b11);
    @(posedge clk); #1;
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    expect_out("t4_clr_coincident", 16'h0009);
    send(8'd0, 8'd1, 8'd1, 2'b11);
    expect_out("t4_after_clr", 16'h000A);
    drain();

    // 5: backpressure
    a0 = n_acc;
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 10; i++)
        send(8'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 2'($urandom_range(0, 1)));
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("t5_in_ready_low", 32'(in_ready), 32'd0);
        chk("t5_held_beats", 32'(n_acc - a0), 32'd3);
        chk("t5_out_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t5_all_accepted", 32'(n_acc - a0), 32'd10);

    // 6: reset with beats in flight
    pulse_clr();
    send(8'h80, 8'h80, 8'h01, 2'b11);
    expect_out("t6_acc_setup", 16'h0100);
    drain();
    out_ready = 1'b0;
    send(8'h01, 8'h02, 8'h03, 2'b01);
    send(8'h04, 8'h05, 8'h06, 2'b01);
    send(8'h07, 8'h08, 8'h09, 2'b01);
    #1;
    reset = 1'b1;
    exp_q.delete();
    acc_m = '0;
    g_m = 0;
    #1;
    chk("t6_async_out_valid", 32'(out_valid), 32'd0);
    chk("t6_async_d", 32'(d), 32'd0);
    chk("t6_async_gate_cnt", 32'(gate_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    send(8'h01, 8'h00, 8'h01, 2'b11);
    lat_check("t6_post_rst", 16'h0001);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/addsub_mac_pipe.md
Name: addsub_mac_pipe

Overview:
Parametrised successor of the fixed 8-bit clock-gated add/sub-multiply datapath. It computes d = (a ± b) * c through a 3-stage pipeline with a valid/ready handshake and full backpressure. It adds an accumulate mode, and zero-operand gating of the multiplier with an event counter. It sits between the operand sequencer and the result sink in the arithmetic datapath.

Parameters:
W, 8, operand width of a, b, c
OUT_W, 16, result/accumulator width; must be ≤ 2*W+1; results truncated to OUT_W LSBs
CNT_W, 16, width of gated-operation counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
a  in  W  operand A (unsigned)
b  in  W  operand B (unsigned)
c  in  W  multiplier operand (unsigned)
mode  in  2  00 = sub, 01 = add, 10 = accumulate-sub, 11 = accumulate-add (mode[0] = add select, mode[1] = accumulate)
in_valid  in  1  input beat valid
in_ready  out  1  pipeline accepts beat this cycle
acc_clr  in  1  synchronous accumulator clear
d  out  OUT_W  result
out_valid  out  1  d valid
out_ready  in  1  sink accepts d
gate_cnt  out  CNT_W  number of results produced with c == 0, saturating

Behaviour:
- Reset (async, active-high): all stage valids 0, d = 0, out_valid = 0, accumulator = 0, gate_cnt = 0, all pipeline data registers 0. On release, in_ready = 1 in the first cycle.
- Stage enables (combinational chain): en3 = !v3 | out_ready; en2 = !v2 | en3; en1 = !v1 | en2; in_ready = en1. Bubbles collapse. There are no combinational paths from in_valid to in_ready.
- Accept: in_valid & in_ready at an edge loads S1 with {a, b, c, mode}.
- S1→S2 on en2: sum = mode[0] ? a+b : a−b, computed in W+1 bits modulo 2^(W+1); a−b wraps in two's complement (e.g. W=8, 0x10−0x20 = 0x1F0). Also register z = (c == 0), c, and mode[1].
- S2→S3 on en3: prod = (sum * c) truncated to OUT_W.
  - If z = 1, the multiplier input registers are not enabled (hold previous values) and prod is forced to 0. gate_cnt increments by 1 (saturates at all-ones).
  - If mode[1] = 0: d = prod.
  - If mode[1] = 1: d = acc' + prod mod 2^OUT_W, and acc <= same value. acc' = 0 if acc_clr is asserted in the same cycle, else acc.
- acc_clr without an S3 accumulate load: acc <= 0 next edge. Non-accumulate loads never modify acc.
- Latency: accepted beat appears on d/out_valid exactly 3 cycles later with no stall. Throughput is 1 beat/cycle.
- Stall: while out_valid & !out_ready, d and out_valid hold stable. Upstream stages fill, then in_ready drops. No beat is lost or duplicated, and order is preserved.
- out_valid = v3; when v3 = 0, d holds its last value.
- Reset mid-operation: all in-flight beats discarded, acc and gate_cnt cleared immediately (asynchronous).
- With W=8, OUT_W=16, modes 00/01 reproduce the previous block bit-exactly: d = ((s ? a+b : a−b) 9-bit × c)[15:0].

Test Plan:
1. Reset, then hold out_ready=1 and send a=0xFF, b=0xFF, c=0xFF, mode=01 → d=0xFC02, out_valid high exactly 3 cycles after acceptance.
2. Send a=0x10, b=0x20, c=0x03, mode=00 → d=0x05D0 (9-bit wrap 0x1F0 × 3). Follow with 300 random back-to-back beats checked against the reference model at 1 beat/cycle.
3. Send 5 beats with c=0x00 (mixed modes), then 5 with c≠0 → the c=0 results are d=0 (or acc unchanged in accumulate mode), gate_cnt=5. Multiplier operand registers are unchanged during the zero beats.
4. Accumulate: mode=11, send (1,2,3) then (4,4,2) → d=0x0009 then 0x0019. Pulse acc_clr, then mode=10, send (5,3,2) → d=0x0004. Pulse acc_clr coincident with an accumulate load → d = prod only.
5. Backpressure: stream 10 beats while holding out_ready=0 for 6 cycles → d stable throughout. in_ready drops after 3 beats are held (S1–S3 full). After release, all 10 results arrive in order with none lost or duplicated.
6. Assert reset with 3 beats in flight and acc=0x0100 → out_valid, d, acc and gate_cnt go to 0 without waiting for a clk edge. The first post-reset beat has 3-cycle latency.
